// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
// Holds the display range limit, the arbiter state encoding and the clamp.
package display_pkg;

   localparam int          IDX_W    = 3;
   localparam logic [31:0] DISP_MAX = 32'd99_999_999;

   typedef enum logic [1:0] {
      IDLE,
      OWN,
      LINGER
   } state_t;

   // Eight decimal digits cannot show more than DISP_MAX; larger values pin to it.
   function automatic logic [63:0] clamp_disp(input logic [63:0] value);
      return (value > 64'(DISP_MAX)) ? 64'(DISP_MAX) : value;
   endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Request/grant bus between the display sources and the display arbiter.
// Sources drive req/req_data; the arbiter drives ownership and the display value.
interface display_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   import display_pkg::*;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic [IDX_W-1:0]          owner;
   logic [DATA_W-1:0]         data_out;
   logic                      data_valid;
   logic                      switch_pulse;

   modport master (
      output req, req_data,
      input  grant, owner, data_out, data_valid, switch_pulse
   );

   modport slave (
      input  req, req_data,
      output grant, owner, data_out, data_valid, switch_pulse
   );

endinterface

// File: rtl/display_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
// The request vector is doubled so a plain shift exposes the wrapped order.
module rr_picker
   import display_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   output logic               found,
   output logic [IDX_W-1:0]   winner
);

   logic [2*NUM_REQ-1:0] doubled;
   logic [NUM_REQ-1:0]   rotated;

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
   always_comb begin
      doubled = {req, req};
      rotated = NUM_REQ'(doubled >> start);
      found   = 1'b0;
      winner  = '0;
      // Descending scan so the lowest rotated position is written last and wins.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            found  = 1'b1;
            winner = (int'(start) + i >= NUM_REQ) ? IDX_W'(int'(start) + i - NUM_REQ)
                                                  : IDX_W'(int'(start) + i);
         end
      end
   end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 8-digit display among NUM_REQ sources, with a
// minimum on-screen hold time and a clamped, registered display value.
module display_arbiter
   import display_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int DATA_W      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   display_arbiter_if.slave bus
);

   localparam int                HOLD_W   = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

   state_t               state, state_nxt;
   logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
   logic [IDX_W-1:0]     rr_ptr, rr_nxt;
   logic [IDX_W-1:0]     owner_q, owner_nxt;
   logic [NUM_REQ-1:0]   grant_q, grant_nxt;
   logic [DATA_W-1:0]    data_q, data_nxt;
   logic                 valid_q, valid_nxt;
   logic                 pulse_q, pulse_nxt;

   logic                 found;
   logic [IDX_W-1:0]     winner;
   logic [DATA_W-1:0]    winner_data, owner_data;
   logic                 hold_done, req_own, take, go_idle;

   // rr_ptr already points one past the last owner, so the previous owner is
   // naturally the lowest-priority candidate in every search.
   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req    (bus.req),
      .start  (rr_ptr),
      .found  (found),
      .winner (winner)
   );

   always_comb begin
      winner_data = '0;
      owner_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == winner)  winner_data = bus.req_data[i*DATA_W +: DATA_W];
         if (IDX_W'(i) == owner_q) owner_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
   end

   assign hold_done = (hold_cnt == HOLD_MAX);
   // grant_q is one-hot on the owner while in OWN, so this is req[owner].
   assign req_own   = |(bus.req & grant_q);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_q;
      owner_nxt = owner_q;
      data_nxt  = data_q;
      valid_nxt = valid_q;
      pulse_nxt = 1'b0;
      rr_nxt    = rr_ptr;
      hold_nxt  = hold_done ? hold_cnt : hold_cnt + 1'b1;
      take      = 1'b0;
      go_idle   = 1'b0;

      unique case (state)
         IDLE: take = found;
         OWN: begin
            if (req_own) begin
               if (hold_done && (winner != owner_q)) take = 1'b1;
               else data_nxt = DATA_W'(clamp_disp(64'(owner_data)));
            end else if (!hold_done) begin
               // Keep the last value on screen until the hold time is honoured.
               state_nxt = LINGER;
               grant_nxt = '0;
            end else if (found) begin
               take = 1'b1;
            end else begin
               go_idle = 1'b1;
            end
         end
         LINGER: begin
            if (hold_done) begin
               if (found) take = 1'b1;
               else go_idle = 1'b1;
            end
         end
         default: go_idle = 1'b1;
      endcase

      if (go_idle) begin
         state_nxt = IDLE;
         grant_nxt = '0;
         valid_nxt = 1'b0;
      end

      if (take) begin
         state_nxt = OWN;
         grant_nxt = NUM_REQ'(1) << winner;
         owner_nxt = winner;
         data_nxt  = DATA_W'(clamp_disp(64'(winner_data)));
         valid_nxt = 1'b1;
         pulse_nxt = 1'b1;
         hold_nxt  = HOLD_W'(1);
         rr_nxt    = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
         rr_ptr   <= '0;
         owner_q  <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         rr_ptr   <= rr_nxt;
         owner_q  <= owner_nxt;
         grant_q  <= grant_nxt;
         data_q   <= data_nxt;
         valid_q  <= valid_nxt;
         pulse_q  <= pulse_nxt;
      end
   end

   assign bus.grant        = grant_q;
   assign bus.owner        = owner_q;
   assign bus.data_out     = data_q;
   assign bus.data_valid   = valid_q;
   assign bus.switch_pulse = pulse_q;

endmodule
